// File: rtl/mul_pkg.sv
// mul_pkg: shared widths and record types for the multiplier final stage.
//   PROD_W    - width of the sum/carry vectors and the full product
//   HALF_W    - split point of the pipelined adder / result word width
//   TAG_W     - reservation-station tag width
//   mul_s1_t  - S1 register contents (low half resolved, high half raw)
//   cdb_pkt_t - held result presented on the common data bus
package mul_pkg;
  localparam int PROD_W = 64;
  localparam int HALF_W = 32;
  localparam int TAG_W  = 4;

  typedef struct packed {
    logic [HALF_W-1:0]        lo;
    logic                     c32;
    logic [PROD_W-HALF_W-1:0] sum_hi;
    logic [PROD_W-HALF_W-1:0] carry_hi;
    logic [TAG_W-1:0]         tag;
    logic                     hi_sel;
  } mul_s1_t;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [HALF_W-1:0] data;
  } cdb_pkt_t;
endpackage

// File: rtl/cpa_half.sv
// cpa_half: W-bit carry-propagate adder with carry-in and carry-out.
//   a, b - addends
//   cin  - carry in
//   sum  - a + b + cin, truncated to W bits
//   cout - carry out of bit W-1
module cpa_half #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
endmodule

// File: rtl/mul_cpa_stage.sv
// mul_cpa_stage: final stage of the Wallace multiplier. Resolves the CSA
// sum/carry pair with a 2-stage carry-propagate adder (low half in S1, high
// half in S2), selects MUL/MULH word and holds it for the CDB arbiter.
//   clk, rst      - clock, async active-high reset
//   flush         - synchronous kill of all in-flight / held results
//   in_valid/in_ready, in_sum, in_carry, in_tag, in_hi_sel - input handshake
//   cdb_req/cdb_grant, cdb_tag, cdb_data - result broadcast handshake
module mul_cpa_stage
  import mul_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_sum,
  input  logic [PROD_W-1:0] in_carry,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              in_hi_sel,
  output logic              cdb_req,
  input  logic              cdb_grant,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [HALF_W-1:0] cdb_data
);
  mul_s1_t  s1_q, s1_d;
  cdb_pkt_t s2_q, s2_d;
  logic     s1_valid_q, s1_valid_d;
  logic     s2_valid_q, s2_valid_d;

  logic [HALF_W-1:0] lo_sum, hi_sum;
  logic              lo_cout, hi_cout_unused;
  logic              s2_load, accept;

  cpa_half #(.W(HALF_W)) u_cpa_lo (
    .a    (in_sum[HALF_W-1:0]),
    .b    (in_carry[HALF_W-1:0]),
    .cin  (1'b0),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  // Carry out of the top half falls off: product is mod 2^PROD_W.
  cpa_half #(.W(HALF_W)) u_cpa_hi (
    .a    (s1_q.sum_hi),
    .b    (s1_q.carry_hi),
    .cin  (s1_q.c32),
    .sum  (hi_sum),
    .cout (hi_cout_unused)
  );

  // S2 frees up when empty or its result is being taken this cycle.
  assign s2_load  = (!s2_valid_q || cdb_grant) && s1_valid_q;
  assign in_ready = !s1_valid_q || s2_load;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    if (accept) begin
      s1_d.lo       = lo_sum;
      s1_d.c32      = lo_cout;
      s1_d.sum_hi   = in_sum[PROD_W-1:HALF_W];
      s1_d.carry_hi = in_carry[PROD_W-1:HALF_W];
      s1_d.tag      = in_tag;
      s1_d.hi_sel   = in_hi_sel;
    end
    if (flush)        s1_valid_d = 1'b0;
    else if (accept)  s1_valid_d = 1'b1;
    else if (s2_load) s1_valid_d = 1'b0;
  end

  always_comb begin
    s2_d       = s2_q;
    s2_valid_d = s2_valid_q;
    if (s2_load && !flush) begin
      s2_d.tag  = s1_q.tag;
      s2_d.data = s1_q.hi_sel ? hi_sum : s1_q.lo;
    end
    // A grant in the flush cycle completes the held result; nothing refills.
    if (flush)          s2_valid_d = 1'b0;
    else if (s2_load)   s2_valid_d = 1'b1;
    else if (cdb_grant) s2_valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q       <= '0;
      s2_q       <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  assign cdb_req  = s2_valid_q;
  assign cdb_tag  = s2_q.tag;
  assign cdb_data = s2_q.data;
endmodule

// File: tb/tb_mul_cpa_stage.sv
module tb_mul_cpa_stage;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_hi_sel;
  logic [63:0] in_sum, in_carry;
  logic [3:0]  in_tag, cdb_tag;
  logic        cdb_req, cdb_grant;
  logic [31:0] cdb_data;

  mul_cpa_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_carry(in_carry), .in_tag(in_tag), .in_hi_sel(in_hi_sel),
    .cdb_req(cdb_req), .cdb_grant(cdb_grant), .cdb_tag(cdb_tag), .cdb_data(cdb_data)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] tag; logic [31:0] data; } exp_t;
  typedef struct { logic [63:0] s, c; logic [3:0] tag; logic hi; logic [31:0] exp; } vec_t;

  exp_t sb[$];
  int   checks = 0, failures = 0;
  int   cyc_no = 0;
  logic acc, fire;
  logic [3:0] fire_tag;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: full 64-bit product, then pick the requested word.
  function automatic logic [31:0] ref_word(input logic [63:0] s, input logic [63:0] c, input logic hi);
    logic [63:0] p;
    p = s + c;
    return hi ? p[63:32] : p[31:0];
  endfunction

  // One clock: sample handshakes just before the edge, update scoreboard,
  // advance past the edge, and check the hold rule.
  task automatic cyc();
    logic h; logic [3:0] ht; logic [31:0] hd;
    exp_t e;
    #3;
    fire = cdb_req && cdb_grant;
    acc  = in_valid && in_ready && !flush;
    fire_tag = cdb_tag;
    h  = cdb_req && !cdb_grant && !flush;
    ht = cdb_tag; hd = cdb_data;
    if (fire) begin
      if (sb.size() == 0) chk("unexpected_broadcast", 1, 0);
      else begin
        e = sb.pop_front();
        chk("sb_tag", cdb_tag, e.tag);
        chk("sb_data", cdb_data, e.data);
      end
    end
    if (flush) sb.delete();
    if (acc) begin
      e.tag  = in_tag;
      e.data = ref_word(in_sum, in_carry, in_hi_sel);
      sb.push_back(e);
    end
    @(posedge clk); #1;
    cyc_no++;
    if (h) begin
      chk("hold_req", cdb_req, 1);
      chk("hold_tag", cdb_tag, ht);
      chk("hold_data", cdb_data, hd);
    end
  endtask

  task automatic drive(input logic [63:0] s, input logic [63:0] c, input logic [3:0] t, input logic hi);
    in_valid = 1'b1; in_sum = s; in_carry = c; in_tag = t; in_hi_sel = hi;
  endtask

  vec_t vt[6];
  int   ft[$];
  int   fc[$];
  int   n;

  initial begin
    vt[0] = '{64'h0000_0000_FFFF_FFFF, 64'h1, 4'd3, 1'b1, 32'h0000_0001};
    vt[1] = '{64'h0000_0000_FFFF_FFFF, 64'h1, 4'd3, 1'b0, 32'h0000_0000};
    vt[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 4'd7, 1'b1, 32'h0000_0000};
    vt[3] = '{64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 4'd9, 1'b0, 32'hABCD_F001};
    vt[4] = '{64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 4'd10, 1'b1, 32'h2345_6789};
    vt[5] = '{64'h8000_0000_8000_0000, 64'h8000_0000_8000_0000, 4'd15, 1'b1, 32'h0000_0001};

    rst = 1; flush = 0; in_valid = 0; in_sum = 0; in_carry = 0; in_tag = 0;
    in_hi_sel = 0; cdb_grant = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", cdb_req, 0);
    chk("rst_tag", cdb_tag, 0);
    chk("rst_data", cdb_data, 0);
    chk("rst_ready", in_ready, 1);
    rst = 0;
    cyc();

    // Table vectors: latency and arithmetic.
    for (int i = 0; i < 6; i++) begin
      drive(vt[i].s, vt[i].c, vt[i].tag, vt[i].hi);
      cdb_grant = 0;
      cyc();
      chk("vec_accept", acc, 1);
      in_valid = 0;
      chk("vec_req_early", cdb_req, 0);
      cyc();
      chk("vec_req", cdb_req, 1);
      chk("vec_tag", cdb_tag, vt[i].tag);
      chk("vec_data", cdb_data, vt[i].exp);
      cdb_grant = 1;
      cyc();
      cdb_grant = 0;
      chk("vec_req_done", cdb_req, 0);
    end

    // Back-pressure: tags 1,2,3 with grant low.
    cdb_grant = 0;
    drive(64'h100, 64'h23, 4'd1, 1'b0); cyc(); chk("bp_acc1", acc, 1);
    drive(64'h200, 64'h45, 4'd2, 1'b1); cyc(); chk("bp_acc2", acc, 1);
    drive(64'h300, 64'h67, 4'd3, 1'b0);
    chk("bp_ready_low", in_ready, 0);
    chk("bp_req", cdb_req, 1);
    chk("bp_tag1", cdb_tag, 1);
    cyc(); cyc();
    chk("bp_tag1_stable", cdb_tag, 1);
    chk("bp_ready_still_low", in_ready, 0);
    cdb_grant = 1;
    ft.delete(); fc.delete();
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (acc) in_valid = 0;
      if (fire) begin ft.push_back(int'(fire_tag)); fc.push_back(cyc_no); end
    end
    chk("bp_count", ft.size(), 3);
    for (int k = 0; k < ft.size(); k++) chk("bp_order", ft[k], k + 1);
    for (int k = 1; k < fc.size(); k++) chk("bp_consecutive", fc[k] - fc[k-1], 1);
    in_valid = 0;

    // Streaming with grant tied high.
    cdb_grant = 1;
    fc.delete(); ft.delete();
    for (int k = 0; k < 10; k++) begin
      if (k < 8) drive($urandom, $urandom, 4'(k + 4), 1'($urandom)); else in_valid = 0;
      if (k < 8) begin #2; chk("str_ready", in_ready, 1); #(-0); end
      cyc();
      if (fire) begin fc.push_back(cyc_no); ft.push_back(int'(fire_tag)); end
    end
    chk("str_count", fc.size(), 8);
    for (int k = 0; k < ft.size(); k++) chk("str_tag", ft[k], k + 4);
    for (int k = 1; k < fc.size(); k++) chk("str_consecutive", fc[k] - fc[k-1], 1);

    // Flush with both stages full and grant in the flush cycle.
    cdb_grant = 0;
    drive(64'h11, 64'h22, 4'd6, 1'b0); cyc();
    drive(64'h33, 64'h44, 4'd7, 1'b0); cyc();
    chk("fl_full_ready", in_ready, 0);
    drive(64'h55, 64'h66, 4'd8, 1'b0);
    flush = 1; cdb_grant = 1;
    n = sb.size();
    cyc();
    chk("fl_fire", fire, 1);
    flush = 0; cdb_grant = 0; in_valid = 0;
    chk("fl_req", cdb_req, 0);
    chk("fl_ready", in_ready, 1);
    cyc(); cyc();
    chk("fl_req_stays_low", cdb_req, 0);

    // Async reset mid-stall.
    drive(64'hABCD, 64'h1234, 4'd5, 1'b0); cyc(); in_valid = 0; cyc();
    chk("ar_req_before", cdb_req, 1);
    chk("ar_tag_before", cdb_tag, 5);
    #2; rst = 1; #1;
    chk("ar_req", cdb_req, 0);
    chk("ar_data", cdb_data, 0);
    chk("ar_tag", cdb_tag, 0);
    chk("ar_ready", in_ready, 1);
    sb.delete();
    @(posedge clk); #1; rst = 0;
    cyc();

    // Random traffic against the scoreboard.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) != 0) drive({$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom), 1'($urandom));
      else in_valid = 0;
      cdb_grant = 1'($urandom);
      flush = ($urandom_range(0, 40) == 0);
      cyc();
    end
    flush = 0; in_valid = 0; cdb_grant = 1;
    n = 0;
    while (sb.size() != 0 && n < 10) begin cyc(); n++; end
    chk("drain_timeout", sb.size(), 0);
    cyc();
    chk("drain_req", cdb_req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
